fsb_traffic_gen_node: RTL and testbench
=======================================

// Module: fsb_traffic_gen_node
// PURPOSE
// - FSB initiator node: the originating end of an FSB link, unlike an echo
//   node, which only responds.
// - Sources numbered 80-bit packets toward the MCL/host bridge and consumes the
//   returned packets. Checks each returned packet in order and reports
//   counts, errors and timeout.
// - Sits in an FSB slot in place of a loopback node, for on-FPGA link self-test.
// PARAMETERS
// - node_id_p          8'h00   value placed in data_o[79:72]
// - tag_p              8'h5A   value placed in data_o[71:64]
// - resp_mask_p        80'h0   expected response = sent packet XOR resp_mask_p
// - max_outstanding_p  4       maximum packets sent but not yet returned (1..15)
// - timeout_p          1024    DRAIN cycles with no accepted packet before abort
// PORTS
// - clk_i          in   1    clock
// - reset_n_i      in   1    asynchronous active-low reset
// - en_i           in   1    0: no new send or receive handshakes; state is held
// - start_i        in   1    1-cycle pulse; honoured only in IDLE or DONE
// - num_pkts_i     in   16   number of packets to send; sampled on start_i
// - v_o            out  1    outbound packet valid
// - data_o         out  80   outbound packet
// - yumi_i         in   1    consumer took data_o this cycle (only when v_o=1)
// - v_i            in   1    returned packet valid
// - data_i         in   80   returned packet
// - ready_o        out  1    node can accept a returned packet
// - busy_o         out  1    state is RUN or DRAIN
// - done_o         out  1    state is DONE
// - timeout_o      out  1    DONE was reached via timeout
// - sent_cnt_o     out  16   packets sent since the last start
// - recv_cnt_o     out  16   packets accepted since the last start
// - err_cnt_o      out  16   mismatching packets; saturates at 16'hFFFF
// - first_err_seq_o out 16   sequence number of the first mismatch (valid if err_cnt_o!=0)
// BEHAVIOUR
// - Reset (async assert, released on a clk_i edge):
//   - state=IDLE; all counters, outstanding count and first_err_seq_o = 0.
//   - v_o, ready_o, busy_o, done_o and timeout_o = 0; data_o=0.
// - Packet seq s: data_o = {node_id_p, tag_p, s, ~s, s, ~s}, where s = sent_cnt_o.
// - FSM: IDLE -start_i-> RUN (if num_pkts_i=0, go straight to DONE).
//   - RUN -> DRAIN in the cycle the last send handshake completes
//     (sent_cnt_o reaches N).
//   - DRAIN -> DONE when recv_cnt_o == N, or when timeout_p consecutive
//     cycles pass with no accepted packet; the timeout path sets timeout_o=1.
//   - DONE -> RUN on start_i. start_i clears all counters, timeout_o and
//     first_err_seq_o, and latches N again.
//   - start_i while busy_o=1 is ignored.
// - Send:
//   - v_o = en_i & RUN & (outstanding < max_outstanding_p).
//   - Once v_o is asserted, data_o stays stable until yumi_i.
//   - yumi_i increments sent_cnt_o in the same cycle.
// - Receive:
//   - ready_o = en_i & (RUN|DRAIN) & (recv_cnt_o < sent_cnt_o).
//   - Accept = v_i & ready_o.
//   - Expected packet = packet with seq recv_cnt_o, XOR resp_mask_p.
//   - On mismatch: err_cnt_o++ (saturating). If err_cnt_o was 0, capture
//     recv_cnt_o into first_err_seq_o.
//   - Every accept increments recv_cnt_o and resets the timeout counter.
// - Outstanding count:
//   - +1 on send, -1 on accept. Both in the same cycle: unchanged.
//   - Never exceeds max_outstanding_p and never underflows, because ready_o
//     gates accepts.
// - Packets are 1 per cycle maximum in each direction. With no backpressure,
//   the first packet goes out one cycle after start_i.
// - Reset mid-run aborts immediately to IDLE; no partial counts are retained.
// TESTING
// - N=8, zero-latency echo (yumi_i=1, response returned 1 cycle later) ->
//   sent=recv=8, err=0, done_o=1, timeout_o=0.
// - N=10, echo delayed 20 cycles, max_outstanding_p=4 -> v_o drops after
//   4 sends until the first return; outstanding never exceeds 4; done with err=0.
// - N=6, responder corrupts seq 2 and seq 4 (bit 0 flipped) -> err_cnt_o=2,
//   first_err_seq_o=2, recv=6.
// - N=5, responder drops seq 3 and returns only 4 packets -> after 1024 idle
//   DRAIN cycles: done_o=1, timeout_o=1, recv=4.
// - N=0 start -> done_o next cycle, v_o never asserted. A start_i pulse
//   mid-run is ignored. A second start from DONE clears all counters.
// - Random yumi_i / v_i stalls, with en_i toggled, N=100 -> data_o stable
//   while stalled; sent=recv=100, err=0. Then assert reset_n_i mid-run ->
//   all outputs 0 asynchronously.

Source files
------------

// File: rtl/fsb_traffic_gen_node.sv
// FSB initiator node: sources numbered 80-bit packets and checks
// the returned stream in order, reporting counts, errors and timeout.
module fsb_traffic_gen_node #(
  parameter logic [7:0]  node_id_p         = 8'h00,
  parameter logic [7:0]  tag_p             = 8'h5A,
  parameter logic [79:0] resp_mask_p       = 80'h0,
  parameter int          max_outstanding_p = 4,
  parameter int          timeout_p         = 1024
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        en_i,
  input  logic        start_i,
  input  logic [15:0] num_pkts_i,
  output logic        v_o,
  output logic [79:0] data_o,
  input  logic        yumi_i,
  input  logic        v_i,
  input  logic [79:0] data_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] sent_cnt_o,
  output logic [15:0] recv_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] first_err_seq_o
);

  localparam int TW = $clog2(timeout_p + 1);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_e;

  state_e state_q, state_d;

  logic [15:0]   n_q, n_d;
  logic [15:0]   sent_q, sent_d;
  logic [15:0]   recv_q, recv_d;
  logic [15:0]   err_q, err_d;
  logic [15:0]   ferr_q, ferr_d;
  logic [3:0]    out_q, out_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;

  logic run_s, drain_s, idle_done_s;
  logic go, send, acc, last_send;
  logic mismatch, tmo_hit, all_recv;

  function automatic logic [79:0] pkt(input logic [15:0] s);
    return {node_id_p, tag_p, s, ~s, s, ~s};
  endfunction

  assign go        = start_i & idle_done_s;
  assign send      = v_o & yumi_i;
  assign acc       = v_i & ready_o;
  assign last_send = send & ((sent_q + 16'd1) == n_q);
  assign mismatch  = data_i != (pkt(recv_q) ^ resp_mask_p);
  assign all_recv  = recv_q == n_q;
  // Only DRAIN cycles with en_i high and no accept advance the timer.
  assign tmo_hit   = en_i & ~acc & (tmo_q == TW'(timeout_p - 1));

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) state_d = (num_pkts_i == 16'd0) ? DONE : RUN;
      end
      RUN: begin
        if (last_send) state_d = DRAIN;
      end
      DRAIN: begin
        if (all_recv || tmo_hit) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State decode and handshake outputs
  always_comb begin
    run_s       = state_q == RUN;
    drain_s     = state_q == DRAIN;
    idle_done_s = (state_q == IDLE) | (state_q == DONE);
    busy_o      = run_s | drain_s;
    done_o      = state_q == DONE;
    v_o         = en_i & run_s & (out_q < 4'(max_outstanding_p));
    ready_o     = en_i & busy_o & (recv_q < sent_q);
    data_o      = run_s ? pkt(sent_q) : 80'h0;
  end

  // Counter and checker next-state
  always_comb begin
    n_d       = n_q;
    sent_d    = sent_q;
    recv_d    = recv_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    out_d     = out_q;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    if (go) begin
      n_d       = num_pkts_i;
      sent_d    = '0;
      recv_d    = '0;
      err_d     = '0;
      ferr_d    = '0;
      out_d     = '0;
      tmo_d     = '0;
      timeout_d = 1'b0;
    end else begin
      if (send) sent_d = sent_q + 16'd1;
      if (acc) begin
        recv_d = recv_q + 16'd1;
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0)    ferr_d = recv_q;
        end
      end
      unique case (1'b1)
        send & ~acc: out_d = out_q + 4'd1;
        acc & ~send: out_d = out_q - 4'd1;
        default:     out_d = out_q;
      endcase
      if (!drain_s)   tmo_d = '0;
      else if (acc)   tmo_d = '0;
      else if (en_i)  tmo_d = tmo_q + TW'(1);
      if (drain_s && tmo_hit && !all_recv) timeout_d = 1'b1;
    end
  end

  // Counter and checker registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      n_q       <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      err_q     <= '0;
      ferr_q    <= '0;
      out_q     <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      n_q       <= n_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      out_q     <= out_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o       = timeout_q;
  assign sent_cnt_o      = sent_q;
  assign recv_cnt_o      = recv_q;
  assign err_cnt_o       = err_q;
  assign first_err_seq_o = ferr_q;

endmodule

// File: tb/tb_fsb_traffic_gen_node.sv
// Directed bench for fsb_traffic_gen_node with a behavioural
// responder that echoes, delays, corrupts or drops packets.
module tb_fsb_traffic_gen_node;

  localparam logic [79:0] MASK = 80'h0000_0000_0000_0000_F00F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] num_pkts_i = '0;
  logic        yumi_i = 1'b0;
  logic        v_i = 1'b0;
  logic [79:0] data_i = '0;
  logic        v_o, ready_o, busy_o, done_o, timeout_o;
  logic [79:0] data_o;
  logic [15:0] sent_cnt_o, recv_cnt_o, err_cnt_o, first_err_seq_o;

  fsb_traffic_gen_node #(.resp_mask_p(MASK)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en_i),
    .start_i(start_i), .num_pkts_i(num_pkts_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .sent_cnt_o(sent_cnt_o), .recv_cnt_o(recv_cnt_o),
    .err_cnt_o(err_cnt_o), .first_err_seq_o(first_err_seq_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [79:0] d;
    int          due;
  } ent_t;
  ent_t q[$];

  bit yumi_on = 1'b1;
  bit rnd = 1'b0;
  bit vo_seen = 1'b0;
  int dly = 1;
  int drop_seq = -1;
  int c1 = -1;
  int c2 = -1;
  int push_cnt = 0;
  int acc_cnt = 0;
  int max_out = 0;
  int data_bad = 0;
  int cyc = 0;

  function automatic logic [79:0] pkt(input logic [15:0] s);
    return {8'h00, 8'h5A, s, ~s, s, ~s};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: drives yumi_i / v_i just after each falling edge.
  always @(negedge clk) begin
    ent_t        e;
    logic [15:0] s;
    if (rnd) en_i = ($urandom_range(0, 3) != 0);
    #1;
    if (push_cnt - acc_cnt > max_out) max_out = push_cnt - acc_cnt;
    if (v_o) begin
      vo_seen = 1'b1;
      if (data_o !== pkt(16'(push_cnt))) data_bad++;
    end
    if (v_o && yumi_on && (!rnd || $urandom_range(0, 1) == 1)) begin
      yumi_i = 1'b1;
      e.d    = data_o;
      e.due  = cyc + (rnd ? int'($urandom_range(1, 3)) : dly);
      q.push_back(e);
      push_cnt++;
    end else begin
      yumi_i = 1'b0;
    end
    v_i = 1'b0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      s = q[0].d[63:48];
      if (int'(s) == drop_seq) void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due <= cyc &&
        (!rnd || $urandom_range(0, 1) == 1)) begin
      s      = q[0].d[63:48];
      v_i    = 1'b1;
      data_i = q[0].d ^ MASK;
      if (int'(s) == c1 || int'(s) == c2) data_i[0] = ~data_i[0];
      if (ready_o) begin
        void'(q.pop_front());
        acc_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] n);
    @(negedge clk);
    num_pkts_i = n;
    start_i    = 1'b1;
    push_cnt   = 0;
    acc_cnt    = 0;
    max_out    = 0;
    data_bad   = 0;
    vo_seen    = 1'b0;
    q.delete();
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int k = 0;
    while (!done_o && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 80'(done_o), 80'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_v", 80'(v_o), 0);
    chk("rst_ready", 80'(ready_o), 0);
    chk("rst_busy", 80'(busy_o), 0);
    chk("rst_done", 80'(done_o), 0);
    chk("rst_data", data_o, 0);
    chk("rst_sent", 80'(sent_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // N=8 zero-latency echo
    start(16'd8);
    chk("t1_busy", 80'(busy_o), 1);
    wait_done(100, "t1_done");
    chk("t1_sent", 80'(sent_cnt_o), 8);
    chk("t1_recv", 80'(recv_cnt_o), 8);
    chk("t1_err", 80'(err_cnt_o), 0);
    chk("t1_tmo", 80'(timeout_o), 0);
    chk("t1_data", 80'(data_bad), 0);

    // N=10 with 20-cycle echo delay: window limit of 4
    dly = 20;
    start(16'd10);
    repeat (8) @(negedge clk);
    chk("t2_sent4", 80'(sent_cnt_o), 4);
    chk("t2_vlow", 80'(v_o), 0);
    wait_done(300, "t2_done");
    chk("t2_recv", 80'(recv_cnt_o), 10);
    chk("t2_err", 80'(err_cnt_o), 0);
    chk("t2_maxout", 80'(max_out), 4);
    dly = 1;

    // N=6 with seq 2 and 4 corrupted
    c1 = 2;
    c2 = 4;
    start(16'd6);
    wait_done(100, "t3_done");
    chk("t3_err", 80'(err_cnt_o), 2);
    chk("t3_ferr", 80'(first_err_seq_o), 2);
    chk("t3_recv", 80'(recv_cnt_o), 6);
    chk("t3_tmo", 80'(timeout_o), 0);
    c1 = -1;
    c2 = -1;

    // N=5 with seq 3 dropped: timeout path
    drop_seq = 3;
    start(16'd5);
    repeat (1000) @(negedge clk);
    chk("t4_busy", 80'(busy_o), 1);
    chk("t4_notdone", 80'(done_o), 0);
    chk("t4_recv_mid", 80'(recv_cnt_o), 4);
    wait_done(200, "t4_done");
    chk("t4_tmo", 80'(timeout_o), 1);
    chk("t4_recv", 80'(recv_cnt_o), 4);
    chk("t4_sent", 80'(sent_cnt_o), 5);
    chk("t4_err", 80'(err_cnt_o), 1);
    chk("t4_ferr", 80'(first_err_seq_o), 3);
    drop_seq = -1;

    // N=0: straight to DONE, previous results cleared
    start(16'd0);
    chk("t5_done", 80'(done_o), 1);
    chk("t5_tmo", 80'(timeout_o), 0);
    chk("t5_err", 80'(err_cnt_o), 0);
    chk("t5_ferr", 80'(first_err_seq_o), 0);
    chk("t5_recv", 80'(recv_cnt_o), 0);
    repeat (5) @(negedge clk);
    chk("t5_novo", 80'(vo_seen), 0);

    // start_i mid-run is ignored
    start(16'd8);
    repeat (3) @(negedge clk);
    num_pkts_i = 16'd2;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("t6_busy", 80'(busy_o), 1);
    wait_done(100, "t6_done");
    chk("t6_sent", 80'(sent_cnt_o), 8);
    chk("t6_recv", 80'(recv_cnt_o), 8);

    // Random stalls and en_i toggling, N=100
    rnd = 1'b1;
    start(16'd100);
    wait_done(5000, "t7_done");
    chk("t7_sent", 80'(sent_cnt_o), 100);
    chk("t7_recv", 80'(recv_cnt_o), 100);
    chk("t7_err", 80'(err_cnt_o), 0);
    chk("t7_data", 80'(data_bad), 0);
    chk("t7_maxok", 80'(max_out <= 4), 1);

    // Asynchronous reset mid-run
    start(16'd100);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_v", 80'(v_o), 0);
    chk("t8_ready", 80'(ready_o), 0);
    chk("t8_busy", 80'(busy_o), 0);
    chk("t8_done", 80'(done_o), 0);
    chk("t8_data", data_o, 0);
    chk("t8_sent", 80'(sent_cnt_o), 0);
    chk("t8_recv", 80'(recv_cnt_o), 0);
    chk("t8_err", 80'(err_cnt_o), 0);
    rnd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
